i2c_target: RTL and testbench

//  I2C target (responder), the far end of the bus driven by our I2C controller and its clock generator.

---
 rtl/i2c_target_pkg.sv | 28 ++
 rtl/i2c_target_if.sv | 27 ++
 rtl/i2c_bus_sync.sv | 61 ++++++
 rtl/i2c_target.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target and its bus synchroniser.
//   - FSM state encoding
//   - default target address and SDA hold time
//   - hold-counter width, which matches the clock generator's counter width
//   - address compare helper
package i2c_target_pkg;

    localparam int          HOLD_W          = 21;
    localparam logic [6:0]  DEFAULT_ADDRESS = 7'h42;
    localparam logic [20:0] DEFAULT_HOLD    = 21'd10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_IGNORE    = 3'd7
    } state_t;

    // The first byte after START carries the 7-bit address in [7:1] and R/W in [0].
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bundle of the I2C target's pad-side and fabric-side signals.
//   scl_in, sda_in : raw pad levels (asynchronous)
//   sda_oe         : 1 = pull SDA low, 0 = release (open drain)
//   rx_data/rx_valid : byte written by the controller, one-cycle valid pulse
//   tx_data/tx_load  : byte to return on a read, captured in the tx_load cycle
//   busy           : target addressed and transfer in progress
// The slave modport is the target; the master modport is the bus/fabric side.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_load, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_load, busy
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA into the clock domain and derives bus event strobes.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   scl_in, sda_in       : raw pad levels
//   sda_lvl              : synchronised SDA level, aligned with the strobes
//   scl_rise, scl_fall   : single-cycle SCL edge strobes
//   start_det, stop_det  : single-cycle START / STOP strobes
// All strobes appear three clocks after the pad change.
module i2c_bus_sync (
    input  logic clock,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic sda_rise_c, sda_fall_c;

    // SCL level before this edge is used, so an SDA fall arriving together
    // with an SCL fall still counts as START.
    assign sda_rise_c = sda_p1 & ~sda_p2;
    assign sda_fall_c = ~sda_p1 & sda_p2;
    assign sda_lvl    = sda_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Idle bus is high; resetting high avoids a spurious START.
            scl_p0    <= 1'b1;
            scl_p1    <= 1'b1;
            scl_p2    <= 1'b1;
            sda_p0    <= 1'b1;
            sda_p1    <= 1'b1;
            sda_p2    <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            // p0/p1: two-flop synchroniser
            scl_p0    <= scl_in;
            scl_p1    <= scl_p0;
            sda_p0    <= sda_in;
            sda_p1    <= sda_p0;
            // p2: delayed copy for edge detection
            scl_p2    <= scl_p1;
            sda_p2    <= sda_p1;
            // strobe stage
            scl_rise  <= scl_p1 & ~scl_p2;
            scl_fall  <= ~scl_p1 & scl_p2;
            start_det <= sda_fall_c & scl_p2;
            stop_det  <= sda_rise_c & scl_p2;
        end
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: matches a 7-bit address, ACKs it, receives written bytes and
// serialises fabric-supplied bytes on reads. SDA is only ever pulled low.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : i2c_target_if.slave (pads, rx/tx fabric handshake, busy)
// Parameters:
//   ADDRESS  : 7-bit target address
//   SDA_HOLD : clocks after a detected SCL fall before sda_oe may change
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]        ADDRESS  = DEFAULT_ADDRESS,
    parameter logic [HOLD_W-1:0] SDA_HOLD = DEFAULT_HOLD
) (
    input  logic         clock,
    input  logic         reset,
    i2c_target_if.slave  bus
);

    logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .sda_lvl   (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Hold timer: reloaded on every SCL fall, fires once when it expires.
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              hold_act_q;
    logic              hold_fire;

    assign hold_fire = hold_act_q && (hold_cnt_q == '0);

    always_ff @(posedge clock) begin
        if (reset || start_det || stop_det) begin
            hold_act_q <= 1'b0;
            hold_cnt_q <= '0;
        end else if (scl_fall) begin
            hold_act_q <= 1'b1;
            hold_cnt_q <= SDA_HOLD;
        end else if (hold_act_q) begin
            if (hold_cnt_q == '0) hold_act_q <= 1'b0;
            else                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
        end
    end

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;   // ACK states: 0 = not yet driving, 1 = ACK/ack-seen
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_c;
    logic [7:0] shift_in;

    assign shift_in = {shreg_q[6:0], sda_lvl};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        rx_valid_d = 1'b0;
        tx_load_c  = 1'b0;

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shreg_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (addr_match(shift_in, ADDRESS)) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = sda_lvl;
                            busy_d  = 1'b1;
                            phase_d = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: if (hold_fire) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d   = ST_READ;
                            tx_load_c = 1'b1;
                            shreg_d   = bus.tx_data;
                            sda_oe_d  = ~bus.tx_data[7];
                        end else begin
                            state_d  = ST_WRITE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shreg_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WRITE_ACK;
                        phase_d    = 1'b0;
                    end
                end
                ST_WRITE_ACK: if (hold_fire) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WRITE;
                    end
                end
                ST_READ: if (hold_fire) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        phase_d   = 1'b0;
                        state_d   = ST_READ_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        sda_oe_d  = ~shreg_q[6];
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_lvl) begin
                            // Controller ACK: fetch the next byte now, drive it after the fall.
                            tx_load_c = 1'b1;
                            shreg_d   = bus.tx_data;
                            phase_d   = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (hold_fire && phase_q) begin
                        state_d   = ST_READ;
                        sda_oe_d  = ~shreg_q[7];
                        bit_cnt_d = 3'd0;
                        phase_d   = 1'b0;
                    end
                end
                default: sda_oe_d = 1'b0;   // IDLE, IGNORE
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            rx_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_load  = tx_load_c;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a behavioural I2C controller drives SCL/SDA
// (wired-AND with the target's sda_oe), with table-driven write/mismatch
// transfers and hand-written read, repeated-START, reset and STOP sequences.
module tb_i2c_target;

    localparam int Q = 50;   // quarter SCL period in clocks

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sda_ctl = 1'b1;

    always #5 clock = ~clock;

    i2c_target_if bus ();

    i2c_target #(.ADDRESS(7'h42), .SDA_HOLD(21'd10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] tx_bytes [16];
    int rx_cnt = 0;
    int tx_load_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    assign bus.sda_in  = sda_ctl & ~bus.sda_oe;
    assign bus.tx_data = tx_bytes[tx_load_cnt[3:0]];

    always @(posedge clock) begin
        if (bus.rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            last_rx <= bus.rx_data;
        end
        if (bus.tx_load)  tx_load_cnt <= tx_load_cnt + 1;
        if (bus.sda_oe)   oe_cnt      <= oe_cnt + 1;
        if (bus.busy)     busy_cnt    <= busy_cnt + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1;     wait_clk(Q);
        bus.scl_in = 1'b1;  wait_clk(Q);
        sda_ctl = 1'b0;     wait_clk(Q);
        bus.scl_in = 1'b0;  wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0;     wait_clk(Q);
        bus.scl_in = 1'b1;  wait_clk(Q);
        sda_ctl = 1'b1;     wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, output logic seen, output logic oe);
        sda_ctl = b;        wait_clk(Q);
        bus.scl_in = 1'b1;  wait_clk(Q);
        seen = bus.sda_in;
        oe   = bus.sda_oe;
        wait_clk(Q);
        bus.scl_in = 1'b0;  wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic oe_ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s, o);
        send_bit(1'b1, s, o);
        acked  = ~s;
        oe_ack = o;
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] val);
        logic s, o;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s, o);
            val[i] = s;
        end
        send_bit(ack_bit, s, o);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic       exp_rx;
        logic [7:0] exp_rx_data;
    } wr_vec_t;

    wr_vec_t vecs [4];

    initial begin
        logic a1, o1, a2, o2;
        logic [7:0] rd;
        int rx0, oe0, busy0, tx0;

        bus.scl_in = 1'b1;
        for (int i = 0; i < 16; i++) tx_bytes[i] = 8'h00;

        vecs[0] = '{8'h84, 8'hA5, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{8'h90, 8'hFF, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{8'h84, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{8'h86, 8'h5A, 1'b0, 1'b0, 8'h00};

        // Reset state
        wait_clk(4);
        check("rst_sda_oe",   32'(bus.sda_oe),   32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_tx_load",  32'(bus.tx_load),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_rx_data",  32'(bus.rx_data),  32'h00);
        reset = 1'b0;
        wait_clk(10);

        // Table: single-byte writes, matching and non-matching addresses
        for (int i = 0; i < 4; i++) begin
            rx0 = rx_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
            i2c_start();
            send_byte(vecs[i].addr, a1, o1);
            send_byte(vecs[i].data, a2, o2);
            check($sformatf("v%0d_addr_ack", i), 32'(a1), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_addr_oe", i),  32'(o1), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_data_ack", i), 32'(a2), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_busy_in", i),  32'(bus.busy), 32'(vecs[i].exp_ack));
            i2c_stop();
            wait_clk(10);
            check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_rx_count", i), 32'(rx_cnt - rx0), 32'(vecs[i].exp_rx));
            if (vecs[i].exp_rx)
                check($sformatf("v%0d_rx_data", i), 32'(last_rx), 32'(vecs[i].exp_rx_data));
            else begin
                check($sformatf("v%0d_oe_never", i), 32'(oe_cnt - oe0), 32'd0);
                check($sformatf("v%0d_busy_never", i), 32'(busy_cnt - busy0), 32'd0);
            end
        end

        // Read two bytes: ACK the first, NACK the second
        tx0 = tx_load_cnt;
        tx_bytes[(tx0 + 0) & 15] = 8'h3C;
        tx_bytes[(tx0 + 1) & 15] = 8'h81;
        i2c_start();
        send_byte(8'h85, a1, o1);
        check("rd_addr_ack", 32'(a1), 32'd1);
        read_byte(1'b0, rd);
        check("rd_byte0", 32'(rd), 32'h3C);
        read_byte(1'b1, rd);
        check("rd_byte1", 32'(rd), 32'h81);
        check("rd_oe_after_nack",   32'(bus.sda_oe), 32'd0);
        check("rd_busy_after_nack", 32'(bus.busy),   32'd0);
        check("rd_tx_loads", 32'(tx_load_cnt - tx0), 32'd2);
        i2c_stop();
        wait_clk(10);

        // Repeated START after a partial write byte, then a read
        rx0 = rx_cnt;
        tx0 = tx_load_cnt;
        tx_bytes[tx0 & 15] = 8'h5A;
        i2c_start();
        send_byte(8'h84, a1, o1);
        check("rs_wr_ack", 32'(a1), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, a2, o2);
        i2c_start();
        send_byte(8'h85, a1, o1);
        check("rs_rd_ack", 32'(a1), 32'd1);
        read_byte(1'b1, rd);
        check("rs_rd_byte", 32'(rd), 32'h5A);
        i2c_stop();
        wait_clk(10);
        check("rs_no_rx", 32'(rx_cnt - rx0), 32'd0);

        // Reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i), a2, o2);
        sda_ctl = 1'b1;
        wait_clk(Q);
        check("rr_oe_before", 32'(bus.sda_oe), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("rr_oe_after",   32'(bus.sda_oe), 32'd0);
        check("rr_busy_after", 32'(bus.busy),   32'd0);
        i2c_stop();
        wait_clk(10);
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'h84, a1, o1);
        send_byte(8'hC3, a2, o2);
        i2c_stop();
        wait_clk(10);
        check("rr_wr_ack0", 32'(a1), 32'd1);
        check("rr_wr_ack1", 32'(a2), 32'd1);
        check("rr_rx_count", 32'(rx_cnt - rx0), 32'd1);
        check("rr_rx_data", 32'(last_rx), 32'hC3);

        // STOP after 5 bits of 0x55
        rx0 = rx_cnt;
        i2c_start();
        send_byte(8'h84, a1, o1);
        for (int i = 7; i >= 3; i--) send_bit(1'(8'h55 >> i), a2, o2);
        i2c_stop();
        wait_clk(10);
        check("sp_ack", 32'(a1), 32'd1);
        check("sp_no_rx", 32'(rx_cnt - rx0), 32'd0);
        check("sp_busy", 32'(bus.busy), 32'd0);
        check("sp_oe", 32'(bus.sda_oe), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
